// File: rtl/label_err_unit.sv
// Label/error stage: fetches the label for each accepted prediction, emits the
// saturated error (label - prediction) and counts sign mismatches per epoch.
module label_err_unit #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   num_samples,
  input  logic              pred_valid,
  output logic              pred_ready,
  input  logic [DATA_W-1:0] pred_data,
  output logic              mem_ena,
  output logic              wr_rd,
  output logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              err_valid,
  input  logic              err_ready,
  output logic [DATA_W-1:0] err_data,
  output logic [ADDR_W-1:0] err_addr,
  output logic [ADDR_W:0]   miss_count,
  output logic              epoch_done,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, ACCEPT, FETCH, CAPT, OUT} state_t;

  localparam logic [ADDR_W:0] MAX_SAMPLES = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [DATA_W-1:0] SAT_POS = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  state_t            state;
  logic [ADDR_W:0]   count;
  logic [ADDR_W-1:0] index;
  logic [DATA_W-1:0] pred_q;
  logic [DATA_W:0]   diff;
  logic [DATA_W-1:0] sat;
  logic              is_last;

  assign wr_rd = 1'b0;

  // One extra bit of headroom so the subtraction itself can never overflow.
  assign diff = {mem_data[DATA_W-1], mem_data} - {pred_q[DATA_W-1], pred_q};

  always_comb begin
    sat = diff[DATA_W-1:0];
    if (diff[DATA_W] != diff[DATA_W-1])
      sat = diff[DATA_W] ? SAT_NEG : SAT_POS;
  end

  assign is_last = ({1'b0, index} == (count - (ADDR_W+1)'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      count      <= MAX_SAMPLES;
      index      <= '0;
      pred_q     <= '0;
      pred_ready <= 1'b0;
      mem_ena    <= 1'b0;
      addr       <= '0;
      err_valid  <= 1'b0;
      err_data   <= '0;
      err_addr   <= '0;
      miss_count <= '0;
      epoch_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      epoch_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= ACCEPT;
            count      <= (num_samples == '0 || num_samples > MAX_SAMPLES) ?
                          MAX_SAMPLES : num_samples;
            index      <= '0;
            miss_count <= '0;
            pred_ready <= 1'b1;
            busy       <= 1'b1;
          end
        end
        ACCEPT: begin
          if (pred_valid) begin
            pred_q     <= pred_data;
            pred_ready <= 1'b0;
            mem_ena    <= 1'b1;
            addr       <= index;
            state      <= FETCH;
          end
        end
        FETCH: begin
          mem_ena <= 1'b0;
          state   <= CAPT;
        end
        CAPT: begin
          err_data  <= sat;
          err_addr  <= index;
          err_valid <= 1'b1;
          // Zero counts as non-negative, so the sign bit alone decides.
          if (mem_data[DATA_W-1] != pred_q[DATA_W-1])
            miss_count <= miss_count + (ADDR_W+1)'(1);
          state <= OUT;
        end
        OUT: begin
          if (err_ready) begin
            err_valid <= 1'b0;
            if (is_last) begin
              epoch_done <= 1'b1;
              busy       <= 1'b0;
              state      <= IDLE;
            end else begin
              index      <= index + ADDR_W'(1);
              pred_ready <= 1'b1;
              state      <= ACCEPT;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_label_err_unit.sv
// Randomized and directed bench for label_err_unit with a label memory model
// and an integer-arithmetic reference for the error and mismatch count.
module tb_label_err_unit;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ADDR_W:0]   num_samples;
  logic              pred_valid;
  logic              pred_ready;
  logic [DATA_W-1:0] pred_data;
  logic              mem_ena;
  logic              wr_rd;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] mem_data;
  logic              err_valid;
  logic              err_ready;
  logic [DATA_W-1:0] err_data;
  logic [ADDR_W-1:0] err_addr;
  logic [ADDR_W:0]   miss_count;
  logic              epoch_done;
  logic              busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [DATA_W-1:0] lbl_mem  [0:1023];
  logic [DATA_W-1:0] pred_tab [0:1023];
  logic [DATA_W-1:0] got_err [$];
  int                last_miss;

  label_err_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
    .pred_valid(pred_valid), .pred_ready(pred_ready), .pred_data(pred_data),
    .mem_ena(mem_ena), .wr_rd(wr_rd), .addr(addr), .mem_data(mem_data),
    .err_valid(err_valid), .err_ready(err_ready), .err_data(err_data),
    .err_addr(err_addr), .miss_count(miss_count), .epoch_done(epoch_done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Label memory: registered read, data valid the cycle after mem_ena.
  always_ff @(posedge clk) begin
    if (mem_ena) mem_data <= lbl_mem[addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] ref_err(input logic [DATA_W-1:0] lbl,
                                                input logic [DATA_W-1:0] prd);
    int d;
    d = int'($signed(lbl)) - int'($signed(prd));
    if (d > 32767) d = 32767;
    if (d < -32768) d = -32768;
    return DATA_W'(d);
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pred_ready"}, 32'(pred_ready), 0);
    check({tag, "_mem_ena"},    32'(mem_ena), 0);
    check({tag, "_wr_rd"},      32'(wr_rd), 0);
    check({tag, "_err_valid"},  32'(err_valid), 0);
    check({tag, "_epoch_done"}, 32'(epoch_done), 0);
    check({tag, "_busy"},       32'(busy), 0);
    check({tag, "_addr"},       32'(addr), 0);
    check({tag, "_err_data"},   32'(err_data), 0);
    check({tag, "_err_addr"},   32'(err_addr), 0);
    check({tag, "_miss"},       32'(miss_count), 0);
  endtask

  // Runs one epoch; rw_fixed >= 0 forces that many err_ready-low cycles per sample.
  task automatic run_epoch(input int ns, input int pw_max, input int rw_fixed,
                           input bit noise);
    int n, miss, w;
    logic [DATA_W-1:0] exp;
    n = (ns == 0 || ns > 1024) ? 1024 : ns;
    got_err.delete();
    miss = 0;
    start = 1'b1; num_samples = (ADDR_W+1)'(ns);
    tick();
    start = 1'b0;
    check("start_busy", 32'(busy), 1);
    check("start_pred_ready", 32'(pred_ready), 1);
    check("start_miss_clr", 32'(miss_count), 0);
    for (int i = 0; i < n; i++) begin
      w = $urandom_range(pw_max, 0);
      for (int k = 0; k < w; k++) begin
        check("acc_pred_ready", 32'(pred_ready), 1);
        check("acc_mem_ena", 32'(mem_ena), 0);
        if (noise && ($urandom_range(1, 0) == 1)) begin
          start = 1'b1; num_samples = (ADDR_W+1)'($urandom_range(5, 1));
        end
        tick();
        start = 1'b0;
      end
      pred_valid = 1'b1; pred_data = pred_tab[i];
      tick();
      pred_valid = 1'b0; pred_data = DATA_W'($urandom);
      check("fetch_mem_ena", 32'(mem_ena), 1);
      check("fetch_addr", 32'(addr), 32'(i));
      check("fetch_pred_ready", 32'(pred_ready), 0);
      check("fetch_wr_rd", 32'(wr_rd), 0);
      tick();
      check("capt_mem_ena", 32'(mem_ena), 0);
      check("capt_addr_hold", 32'(addr), 32'(i));
      tick();
      exp = ref_err(lbl_mem[i], pred_tab[i]);
      if (lbl_mem[i][DATA_W-1] != pred_tab[i][DATA_W-1]) miss++;
      check("out_err_valid", 32'(err_valid), 1);
      check("out_err_data", 32'(err_data), 32'(exp));
      check("out_err_addr", 32'(err_addr), 32'(i));
      check("out_miss", 32'(miss_count), 32'(miss));
      got_err.push_back(err_data);
      w = (rw_fixed >= 0) ? rw_fixed : $urandom_range(3, 0);
      for (int k = 0; k < w; k++) begin
        tick();
        check("hold_err_valid", 32'(err_valid), 1);
        check("hold_err_data", 32'(err_data), 32'(exp));
        check("hold_err_addr", 32'(err_addr), 32'(i));
        check("hold_pred_ready", 32'(pred_ready), 0);
        check("hold_mem_ena", 32'(mem_ena), 0);
      end
      err_ready = 1'b1;
      if (i == n - 1 && noise) start = 1'b1;
      tick();
      err_ready = 1'b0; start = 1'b0;
      if (i == n - 1) begin
        check("done_pulse", 32'(epoch_done), 1);
        check("done_busy", 32'(busy), 0);
        check("done_err_valid", 32'(err_valid), 0);
        check("done_miss", 32'(miss_count), 32'(miss));
        tick();
        check("after_done_pulse", 32'(epoch_done), 0);
        check("after_done_busy", 32'(busy), 0);
        check("after_done_pred_ready", 32'(pred_ready), 0);
        check("after_done_miss_hold", 32'(miss_count), 32'(miss));
      end else begin
        check("next_no_done", 32'(epoch_done), 0);
        check("next_pred_ready", 32'(pred_ready), 1);
        check("next_busy", 32'(busy), 1);
      end
    end
    last_miss = miss;
    $display("epoch num_samples=%0d samples=%0d miss=%0d", ns, n, miss);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; num_samples = '0; pred_valid = 1'b0;
    pred_data = '0; err_ready = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      lbl_mem[i] = DATA_W'($urandom);
      pred_tab[i] = DATA_W'($urandom);
    end
    tick(); tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    pred_valid = 1'b1;
    tick(); tick();
    check("idle_no_activity_busy", 32'(busy), 0);
    check("idle_no_activity_mem", 32'(mem_ena), 0);
    pred_valid = 1'b0;

    // Single-sample epoch.
    lbl_mem[0] = 16'h0200; pred_tab[0] = 16'h0080;
    run_epoch(1, 0, 0, 1'b0);
    check("single_err", 32'(got_err[0]), 32'h0180);
    check("single_miss", 32'(last_miss), 0);

    // Saturation both ways.
    lbl_mem[0] = 16'h7000; pred_tab[0] = 16'h9000;
    lbl_mem[1] = 16'h9000; pred_tab[1] = 16'h7000;
    run_epoch(2, 1, 0, 1'b0);
    check("sat_pos", 32'(got_err[0]), 32'h7FFF);
    check("sat_neg", 32'(got_err[1]), 32'h8000);
    check("sat_miss", 32'(last_miss), 2);

    // Three samples, zero label counts as non-negative; long err_ready stall.
    lbl_mem[0] = 16'h0200; pred_tab[0] = 16'h0100;
    lbl_mem[1] = 16'hFE00; pred_tab[1] = 16'h0100;
    lbl_mem[2] = 16'h0000; pred_tab[2] = 16'hFF00;
    run_epoch(3, 2, 5, 1'b1);
    check("three_err0", 32'(got_err[0]), 32'h0100);
    check("three_err1", 32'(got_err[1]), 32'hFD00);
    check("three_err2", 32'(got_err[2]), 32'h0100);
    check("three_miss", 32'(last_miss), 2);

    // Reset in CAPT of sample 1.
    start = 1'b1; num_samples = 11'd3;
    tick();
    start = 1'b0;
    pred_valid = 1'b1; pred_data = pred_tab[0];
    tick();
    pred_valid = 1'b0;
    tick(); tick();
    err_ready = 1'b1;
    tick();
    err_ready = 1'b0;
    pred_valid = 1'b1; pred_data = pred_tab[1];
    tick();
    pred_valid = 1'b0;
    tick();
    check("pre_reset_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    check("post_reset_busy", 32'(busy), 0);
    check("post_reset_err_valid", 32'(err_valid), 0);
    check("post_reset_mem_ena", 32'(mem_ena), 0);

    // Randomized epochs with ignored start pulses while busy.
    for (int e = 0; e < 12; e++) begin
      for (int i = 0; i < 16; i++) begin
        lbl_mem[i] = DATA_W'($urandom);
        pred_tab[i] = DATA_W'($urandom);
        if ($urandom_range(3, 0) == 0) lbl_mem[i] = 16'h0000;
        if ($urandom_range(3, 0) == 0) pred_tab[i] = 16'h8000;
      end
      run_epoch($urandom_range(16, 1), 3, -1, 1'b1);
    end

    // Boundary counts: 0 and >1024 both mean a full 1024-sample epoch.
    run_epoch(0, 0, 0, 1'b0);
    check("full0_last_addr", 32'(err_addr), 1023);
    run_epoch(1100, 0, 0, 1'b0);
    check("full1100_last_addr", 32'(err_addr), 1023);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
